rr_mux_collect: RTL



---
 rtl/rr_mux_collect.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rr_mux_collect.sv
// rr_mux_collect
// ----------------------------------------------------------------------------
// Round-robin N-to-1 collector (N = 2**S). It arbitrates fairly among N
// valid/ready input channels and forwards at most one word per cycle into a
// single registered output channel. Each word is tagged with the index of
// the channel that supplied it. Use it to merge demuxed lanes back onto one
// shared stream.
//
// Parameters
//   S : select width, N = 2**S channels (S >= 1)
//   T : data width per channel
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : [N-1:0]   per-channel request
//   in_data    : [N*T-1:0] channel i at bits [(i+1)*T-1 : i*T]
//   in_ready   : [N-1:0]   one-hot or zero; the channel accepted this cycle
//   out_valid  : output register holds a word
//   out_data   : [T-1:0]   registered word
//   out_sel    : [S-1:0]   source channel of out_data
//   out_ready  : downstream accepts when out_valid & out_ready
// ----------------------------------------------------------------------------
module rr_mux_collect #(
    parameter int S = 1,
    parameter int T = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(2**S)-1:0]     in_valid,
    input  logic [(2**S)*T-1:0]   in_data,
    output logic [(2**S)-1:0]     in_ready,
    output logic                  out_valid,
    output logic [T-1:0]          out_data,
    output logic [S-1:0]          out_sel,
    input  logic                  out_ready
);

    localparam int N = 2**S;

    // Output register and round-robin pointer
    logic           out_valid_q, out_valid_d;
    logic [T-1:0]   out_data_q,  out_data_d;
    logic [S-1:0]   out_sel_q,   out_sel_d;
    logic [S-1:0]   ptr_q,       ptr_d;

    logic           load_en;
    logic           found;
    logic [S-1:0]   cand;
    logic [S-1:0]   grant_idx;
    logic [N-1:0]   grant;
    logic [T-1:0]   grant_data;

    // The register can take a new word when it is empty or draining now.
    // This allows a drain and a load on the same edge, so there is no bubble.
    assign load_en = ~out_valid_q | out_ready;

    // Rotating priority search. ptr_q is the highest-priority channel.
    // The S-bit add wraps modulo N.
    // NOTE: combinational blocks use blocking assignments, and every output
    // gets a default first so no path leaves a value unassigned (no latch).
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + S'(k);
            if (!found && in_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant = '0;
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Select the granted channel's word with a one-hot AND-OR over constant slices.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*T +: T];
            end
        end
    end

    // in_ready is held low while reset is asserted. Without this gate, the
    // empty register would show a grant to channels that are still
    // requesting during reset.
    assign in_ready = (load_en && !rst) ? grant : '0;

    // Next-state logic
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (found) begin
                out_valid_d = 1'b1;
                out_data_d  = grant_data;
                out_sel_d   = grant_idx;
                // Priority moves to the channel just after the winner.
                ptr_d       = grant_idx + S'(1);
            end else begin
                // Empty or drained with nothing to load. Data, tag and ptr hold.
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments. The data
    // register is also cleared on reset, so out_data reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
